// File: rtl/dig_pkg.sv
// Shared constants and types for the dig map and its frame-rate helpers.
package dig_pkg;

  localparam int unsigned COLS       = 32;
  localparam int unsigned ROWS       = 24;
  localparam int unsigned TILE_SHIFT = 4;
  localparam int unsigned FIELD_Y0   = 96;
  localparam int unsigned MAX_TILES  = 768;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WRITE,
    CLEAR
  } dig_state_t;

  typedef logic [ROWS-1:0] dug_col_t;

endpackage

// File: rtl/tick_sync.sv
// Brings an asynchronous level into the local clock domain and emits a
// one-cycle pulse on each rising edge of it.
module tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchroniser followed by an edge-detect history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Rising edge seen on the synchronised level.
  always_comb begin
    tick = sync2_q & ~prev_q;
  end

endmodule

// File: rtl/dig_map.sv
// Dug-tile map for the playfield: once per frame marks the tile under the
// player centre as dug, counts newly dug tiles, and sweeps the map clean on
// a level-clear request.
module dig_map
  import dig_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_clk,
  input  logic                 dig_en,
  input  logic [9:0]           player_x,
  input  logic [9:0]           player_y,
  input  logic                 level_clear,
  output dug_col_t [COLS-1:0]  dug_state,
  output logic                 dig_event,
  output logic [9:0]           tiles_dug,
  output logic                 busy
);

  logic tick;

  dig_state_t          state_q, state_d;
  logic [4:0]          tile_col_q, tile_col_d;
  logic [4:0]          tile_row_q, tile_row_d;
  logic                tile_valid_q, tile_valid_d;
  logic [4:0]          sweep_q, sweep_d;
  logic                pend_q, pend_d;
  logic                busy_q, busy_d;
  logic                ev_q, ev_d;
  logic [9:0]          cnt_q, cnt_d;
  dug_col_t [COLS-1:0] dug_q, dug_d;

  logic [10:0] cx, cy, cy_off, col_full, row_full;
  logic        calc_valid;
  logic        new_dig;

  tick_sync u_tick_sync (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .async_in (frame_clk),
    .tick     (tick)
  );

  // Tile under the sprite centre; widened to 11 bits so +8 cannot overflow.
  always_comb begin
    cx         = {1'b0, player_x} + 11'd8;
    cy         = {1'b0, player_y} + 11'd8;
    cy_off     = cy - 11'(FIELD_Y0);
    col_full   = cx >> TILE_SHIFT;
    row_full   = cy_off >> TILE_SHIFT;
    calc_valid = (cy >= 11'(FIELD_Y0)) && (col_full < 11'(COLS)) && (row_full < 11'(ROWS));
    new_dig    = tile_valid_q && !dug_q[tile_col_q][tile_row_q];
  end

  // Next-state logic for the dig / clear sequencer.
  always_comb begin
    state_d      = state_q;
    tile_col_d   = tile_col_q;
    tile_row_d   = tile_row_q;
    tile_valid_d = tile_valid_q;
    sweep_d      = sweep_q;
    pend_d       = pend_q;
    busy_d       = busy_q;
    ev_d         = 1'b0;
    cnt_d        = cnt_q;
    dug_d        = dug_q;

    case (state_q)
      IDLE: begin
        // Clear wins over a same-cycle tick; that tick is simply lost.
        if (level_clear) begin
          state_d = CLEAR;
          sweep_d = '0;
          busy_d  = 1'b1;
        end else if (tick && dig_en) begin
          state_d = CALC;
        end
      end
      CALC: begin
        tile_col_d   = col_full[4:0];
        tile_row_d   = row_full[4:0];
        tile_valid_d = calc_valid;
        if (level_clear) pend_d = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        if (new_dig) begin
          dug_d[tile_col_q][tile_row_q] = 1'b1;
          ev_d = 1'b1;
          if (cnt_q < 10'(MAX_TILES)) cnt_d = cnt_q + 10'd1;
        end
        if (pend_q || level_clear) begin
          state_d = CLEAR;
          sweep_d = '0;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        dug_d[sweep_q] = '0;
        if (sweep_q == 5'd0) cnt_d = '0;
        if (sweep_q == 5'(COLS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          sweep_d = sweep_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; everything the colour mapper sees is a flop.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      tile_col_q   <= '0;
      tile_row_q   <= '0;
      tile_valid_q <= 1'b0;
      sweep_q      <= '0;
      pend_q       <= 1'b0;
      busy_q       <= 1'b0;
      ev_q         <= 1'b0;
      cnt_q        <= '0;
      dug_q        <= '0;
    end else begin
      state_q      <= state_d;
      tile_col_q   <= tile_col_d;
      tile_row_q   <= tile_row_d;
      tile_valid_q <= tile_valid_d;
      sweep_q      <= sweep_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      ev_q         <= ev_d;
      cnt_q        <= cnt_d;
      dug_q        <= dug_d;
    end
  end

  // Drive ports straight from the registers.
  always_comb begin
    dug_state = dug_q;
    dig_event = ev_q;
    tiles_dug = cnt_q;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_dig_map.sv
// Self-checking bench for dig_map against a tile-level reference model.
module tb_dig_map;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              frame_clk;
  logic              dig_en;
  logic [9:0]        player_x;
  logic [9:0]        player_y;
  logic              level_clear;
  logic [31:0][23:0] dug_state;
  logic              dig_event;
  logic [9:0]        tiles_dug;
  logic              busy;

  int tests_run = 0;
  int fails     = 0;
  int ev_total  = 0;

  bit model [32][24];
  int model_cnt;

  dig_map dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .dig_en      (dig_en),
    .player_x    (player_x),
    .player_y    (player_y),
    .level_clear (level_clear),
    .dug_state   (dug_state),
    .dig_event   (dig_event),
    .tiles_dug   (tiles_dug),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  // Count dig pulses as they are seen mid-cycle.
  always @(negedge Clk) if (dig_event === 1'b1) ev_total++;

  initial begin
    #900000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference: centre-of-sprite tile, dug once, counted with saturation.
  task automatic model_frame(input int x, input int y, input bit en, output int pulses);
    int cx, cy, c, r;
    pulses = 0;
    cx = x + 8;
    cy = y + 8;
    if (!en || cy < 96) return;
    c = cx / 16;
    r = (cy - 96) / 16;
    if (c >= 32 || r >= 24) return;
    if (!model[c][r]) begin
      model[c][r] = 1'b1;
      pulses = 1;
      if (model_cnt < 768) model_cnt++;
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 24; r++) model[c][r] = 1'b0;
    model_cnt = 0;
  endtask

  function automatic logic [767:0] model_grid();
    logic [767:0] g;
    g = '0;
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 24; r++) g[c*24 + r] = model[c][r];
    return g;
  endfunction

  // One frame pulse with the given position; ends mid-cycle, well after the write.
  task automatic drive_frame(input int x, input int y, input bit en);
    @(posedge Clk); #1;
    player_x  = 10'(x);
    player_y  = 10'(y);
    dig_en    = en;
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (6) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; frame_clk = 1'b0; dig_en = 1'b0; level_clear = 1'b0;
    player_x = '0; player_y = '0;
    model_clear();
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(negedge Clk);
    tests_run++; if (dug_state !== '0) begin fails++;
      $display("FAIL reset_grid got %h want 0", dug_state); end
    tests_run++; if (tiles_dug !== 10'd0) begin fails++;
      $display("FAIL reset_count got %0d want 0", tiles_dug); end
    tests_run++; if (dig_event !== 1'b0) begin fails++;
      $display("FAIL reset_event got %b want 0", dig_event); end
    tests_run++; if (busy !== 1'b0) begin fails++;
      $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic_dig();
    int ev0, exp;
    for (int k = 0; k < 3; k++) begin
      ev0 = ev_total;
      model_frame(100, 200, 1'b1, exp);
      drive_frame(100, 200, 1'b1);
      tests_run++; if (dug_state !== model_grid()) begin fails++;
        $display("FAIL basic_grid[%0d] got %h want %h", k, dug_state, model_grid()); end
      tests_run++; if (dug_state[6][7] !== 1'b1) begin fails++;
        $display("FAIL basic_bit_6_7[%0d] got %b want 1", k, dug_state[6][7]); end
      tests_run++; if (ev_total - ev0 !== exp) begin fails++;
        $display("FAIL basic_events[%0d] got %0d want %0d", k, ev_total - ev0, exp); end
      tests_run++; if (tiles_dug !== 10'd1) begin fails++;
        $display("FAIL basic_count[%0d] got %0d want 1", k, tiles_dug); end
    end
  endtask

  task automatic test_boundaries();
    int xs [3] = '{100, 510, 500};
    int ys [3] = '{80, 200, 470};
    int ev0, exp;
    for (int k = 0; k < 3; k++) begin
      ev0 = ev_total;
      model_frame(xs[k], ys[k], 1'b1, exp);
      drive_frame(xs[k], ys[k], 1'b1);
      tests_run++; if (dug_state !== model_grid()) begin fails++;
        $display("FAIL bound_grid[%0d] got %h want %h", k, dug_state, model_grid()); end
      tests_run++; if (ev_total - ev0 !== exp) begin fails++;
        $display("FAIL bound_events[%0d] got %0d want %0d", k, ev_total - ev0, exp); end
      tests_run++; if (tiles_dug !== 10'(model_cnt)) begin fails++;
        $display("FAIL bound_count[%0d] got %0d want %0d", k, tiles_dug, model_cnt); end
    end
    tests_run++; if (dug_state[31][23] !== 1'b1) begin fails++;
      $display("FAIL bound_corner got %b want 1", dug_state[31][23]); end
  endtask

  task automatic test_random();
    int ev0, exp, x, y;
    bit en;
    for (int k = 0; k < 40; k++) begin
      x  = int'($urandom_range(0, 560));
      y  = int'($urandom_range(0, 540));
      en = ($urandom_range(0, 3) != 0);
      ev0 = ev_total;
      model_frame(x, y, en, exp);
      drive_frame(x, y, en);
      tests_run++; if (dug_state !== model_grid()) begin fails++;
        $display("FAIL rand_grid[%0d] x=%0d y=%0d en=%b", k, x, y, en); end
      tests_run++; if (ev_total - ev0 !== exp) begin fails++;
        $display("FAIL rand_events[%0d] got %0d want %0d", k, ev_total - ev0, exp); end
      tests_run++; if (tiles_dug !== 10'(model_cnt)) begin fails++;
        $display("FAIL rand_count[%0d] got %0d want %0d", k, tiles_dug, model_cnt); end
    end
  endtask

  task automatic test_clear_sweep();
    int ev0, exp, bc;
    for (int i = 0; i < 5; i++) begin
      model_frame(16*i + 200, 96 + 16*i, 1'b1, exp);
      drive_frame(16*i + 200, 96 + 16*i, 1'b1);
    end
    tests_run++; if (tiles_dug !== 10'(model_cnt)) begin fails++;
      $display("FAIL clear_precount got %0d want %0d", tiles_dug, model_cnt); end
    ev0 = ev_total;
    @(posedge Clk); #1 level_clear = 1'b1; dig_en = 1'b1;
    @(posedge Clk); #1 level_clear = 1'b0; frame_clk = 1'b1;
    model_clear();
    bc = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge Clk);
      if (busy === 1'b1) begin
        bc++;
        if (bc == 2) begin
          tests_run++; if (tiles_dug !== 10'd0) begin fails++;
            $display("FAIL clear_count_early got %0d want 0", tiles_dug); end
        end
        if (bc == 6) frame_clk = 1'b0;
      end else if (bc > 0) break;
    end
    repeat (10) @(negedge Clk);
    tests_run++; if (bc !== 32) begin fails++;
      $display("FAIL clear_busy_cycles got %0d want 32", bc); end
    tests_run++; if (dug_state !== '0) begin fails++;
      $display("FAIL clear_grid got %h want 0", dug_state); end
    tests_run++; if (tiles_dug !== 10'd0) begin fails++;
      $display("FAIL clear_count got %0d want 0", tiles_dug); end
    tests_run++; if (ev_total - ev0 !== 0) begin fails++;
      $display("FAIL clear_tick_dropped got %0d events want 0", ev_total - ev0); end
  endtask

  task automatic test_clear_vs_tick();
    int ev0, bc;
    ev0 = ev_total;
    @(posedge Clk); #1;
    player_x = 10'd100; player_y = 10'd200; dig_en = 1'b1; frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk); #1 level_clear = 1'b1;
    @(posedge Clk); #1 level_clear = 1'b0;
    bc = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge Clk);
      if (busy === 1'b1) bc++;
      else if (bc > 0) break;
    end
    frame_clk = 1'b0;
    repeat (10) @(negedge Clk);
    tests_run++; if (bc !== 32) begin fails++;
      $display("FAIL same_cycle_busy got %0d want 32", bc); end
    tests_run++; if (dug_state !== '0) begin fails++;
      $display("FAIL same_cycle_grid got %h want 0", dug_state); end
    tests_run++; if (ev_total - ev0 !== 0) begin fails++;
      $display("FAIL same_cycle_events got %0d want 0", ev_total - ev0); end
  endtask

  task automatic test_clear_during_write();
    int exp, bc;
    model_frame(100, 200, 1'b1, exp);
    @(posedge Clk); #1;
    player_x = 10'd100; player_y = 10'd200; dig_en = 1'b1; frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1 level_clear = 1'b1;
    @(posedge Clk); #1 level_clear = 1'b0; frame_clk = 1'b0;
    @(negedge Clk);
    tests_run++; if (dig_event !== 1'b1) begin fails++;
      $display("FAIL wr_clear_event got %b want 1", dig_event); end
    tests_run++; if (busy !== 1'b1) begin fails++;
      $display("FAIL wr_clear_busy got %b want 1", busy); end
    tests_run++; if (tiles_dug !== 10'(model_cnt)) begin fails++;
      $display("FAIL wr_clear_count got %0d want %0d", tiles_dug, model_cnt); end
    tests_run++; if (dug_state[6][7] !== 1'b1) begin fails++;
      $display("FAIL wr_clear_bit got %b want 1", dug_state[6][7]); end
    bc = 1;
    for (int t = 0; t < 40; t++) begin
      @(negedge Clk);
      if (busy === 1'b1) bc++;
      else break;
    end
    model_clear();
    tests_run++; if (bc !== 32) begin fails++;
      $display("FAIL wr_clear_busy_cycles got %0d want 32", bc); end
    tests_run++; if (dug_state !== model_grid() || tiles_dug !== 10'd0) begin fails++;
      $display("FAIL wr_clear_final grid=%h count=%0d want all 0", dug_state, tiles_dug); end
  endtask

  task automatic test_saturation();
    int ev0, exp;
    ev0 = ev_total;
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 24; r++) begin
        model_frame(c*16, 96 + r*16, 1'b1, exp);
        drive_frame(c*16, 96 + r*16, 1'b1);
      end
    tests_run++; if (tiles_dug !== 10'd768) begin fails++;
      $display("FAIL sat_full_count got %0d want 768", tiles_dug); end
    tests_run++; if (dug_state !== model_grid()) begin fails++;
      $display("FAIL sat_full_grid got %h want %h", dug_state, model_grid()); end
    tests_run++; if (ev_total - ev0 !== 768) begin fails++;
      $display("FAIL sat_events got %0d want 768", ev_total - ev0); end
    ev0 = ev_total;
    model_frame(300, 300, 1'b1, exp);
    drive_frame(300, 300, 1'b1);
    tests_run++; if (tiles_dug !== 10'(model_cnt)) begin fails++;
      $display("FAIL sat_hold_count got %0d want %0d", tiles_dug, model_cnt); end
    tests_run++; if (ev_total - ev0 !== exp) begin fails++;
      $display("FAIL sat_hold_events got %0d want %0d", ev_total - ev0, exp); end
  endtask

  task automatic test_reset_mid_sweep();
    @(posedge Clk); #1 level_clear = 1'b1;
    @(posedge Clk); #1 level_clear = 1'b0;
    repeat (10) @(posedge Clk);
    #3;
    tests_run++; if (busy !== 1'b1 || dug_state[31] !== 24'hFFFFFF) begin fails++;
      $display("FAIL midsweep_pre busy=%b col31=%h want 1/ffffff", busy, dug_state[31]); end
    Reset_n = 1'b0;
    #1;
    tests_run++; if (dug_state !== '0) begin fails++;
      $display("FAIL async_rst_grid got %h want 0", dug_state); end
    tests_run++; if (busy !== 1'b0 || dig_event !== 1'b0 || tiles_dug !== 10'd0) begin fails++;
      $display("FAIL async_rst_outs busy=%b ev=%b cnt=%0d want 0/0/0", busy, dig_event,
               tiles_dug); end
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    model_clear();
    repeat (40) @(negedge Clk);
    tests_run++; if (busy !== 1'b0 || dug_state !== '0) begin fails++;
      $display("FAIL post_rst_idle busy=%b grid=%h want 0", busy, dug_state); end
  endtask

  initial begin
    test_reset();
    test_basic_dig();
    test_boundaries();
    test_random();
    test_clear_sweep();
    test_clear_vs_tick();
    test_clear_during_write();
    test_saturation();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
